// File: rtl/banked_ram_arb.sv
// Two-port banked scratchpad with per-bank round-robin arbitration.
// Reads and writes are arbitrated independently, and a read that collides with a write can bypass it.
module banked_ram_arb #(
    parameter int TAG_W       = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 13,
    parameter int WRITE_FIRST = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  s_read_req_a,
    input  logic [ADDR_WIDTH-1:0] s_read_addr_a,
    output logic                  s_read_ready_a,
    output logic [DATA_WIDTH-1:0] s_read_data_a,
    output logic                  s_read_valid_a,
    input  logic                  s_write_req_a,
    input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
    input  logic [DATA_WIDTH-1:0] s_write_data_a,
    output logic                  s_write_ready_a,

    input  logic                  s_read_req_b,
    input  logic [ADDR_WIDTH-1:0] s_read_addr_b,
    output logic                  s_read_ready_b,
    output logic [DATA_WIDTH-1:0] s_read_data_b,
    output logic                  s_read_valid_b,
    input  logic                  s_write_req_b,
    input  logic [ADDR_WIDTH-1:0] s_write_addr_b,
    input  logic [DATA_WIDTH-1:0] s_write_data_b,
    output logic                  s_write_ready_b,

    output logic [CNT_W-1:0]      stall_count
);

    localparam int NUM_BANKS = 1 << TAG_W;
    localparam int LOCAL_W   = ADDR_WIDTH - TAG_W;
    localparam int DEPTH     = 1 << LOCAL_W;

    logic [TAG_W-1:0]   rd_bank_a, rd_bank_b, wr_bank_a, wr_bank_b;
    logic [LOCAL_W-1:0] rd_loc_a, rd_loc_b, wr_loc_a, wr_loc_b;

    assign rd_bank_a = s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
    assign rd_bank_b = s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];
    assign wr_bank_a = s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
    assign wr_bank_b = s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
    assign rd_loc_a  = s_read_addr_a[LOCAL_W-1:0];
    assign rd_loc_b  = s_read_addr_b[LOCAL_W-1:0];
    assign wr_loc_a  = s_write_addr_a[LOCAL_W-1:0];
    assign wr_loc_b  = s_write_addr_b[LOCAL_W-1:0];

    // A pointer bit of 1 means port B wins the next conflict on that bank.
    logic [NUM_BANKS-1:0] rd_ptr, wr_ptr;

    logic rd_conflict, wr_conflict;
    logic rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b;

    assign rd_conflict = s_read_req_a && s_read_req_b && (rd_bank_a == rd_bank_b);
    assign wr_conflict = s_write_req_a && s_write_req_b && (wr_bank_a == wr_bank_b);

    assign rd_gnt_a = s_read_req_a  && (!rd_conflict || !rd_ptr[rd_bank_a]);
    assign rd_gnt_b = s_read_req_b  && (!rd_conflict ||  rd_ptr[rd_bank_b]);
    assign wr_gnt_a = s_write_req_a && (!wr_conflict || !wr_ptr[wr_bank_a]);
    assign wr_gnt_b = s_write_req_b && (!wr_conflict ||  wr_ptr[wr_bank_b]);

    assign s_read_ready_a  = rd_gnt_a;
    assign s_read_ready_b  = rd_gnt_b;
    assign s_write_ready_a = wr_gnt_a;
    assign s_write_ready_b = wr_gnt_b;

    // Only a real conflict moves a pointer; an uncontested grant leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rd_conflict)
                rd_ptr[rd_bank_a] <= ~rd_ptr[rd_bank_a];
            if (wr_conflict)
                wr_ptr[wr_bank_a] <= ~wr_ptr[wr_bank_a];
        end
    end

    logic any_stall;

    assign any_stall = (s_read_req_a  && !rd_gnt_a) || (s_read_req_b  && !rd_gnt_b) ||
                       (s_write_req_a && !wr_gnt_a) || (s_write_req_b && !wr_gnt_b);

    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (any_stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
    end

    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_q;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic                  sel_rd_a, sel_rd_b, sel_wr_a, sel_wr_b;
        logic                  rd_en, wr_en, bypass;
        logic [LOCAL_W-1:0]    rd_loc, wr_loc;
        logic [DATA_WIDTH-1:0] wr_dat;
        logic [DATA_WIDTH-1:0] q;

        assign sel_rd_a = rd_gnt_a && (rd_bank_a == TAG_W'(k));
        assign sel_rd_b = rd_gnt_b && (rd_bank_b == TAG_W'(k));
        assign sel_wr_a = wr_gnt_a && (wr_bank_a == TAG_W'(k));
        assign sel_wr_b = wr_gnt_b && (wr_bank_b == TAG_W'(k));

        assign rd_en  = sel_rd_a || sel_rd_b;
        assign rd_loc = sel_rd_b ? rd_loc_b : rd_loc_a;
        assign wr_en  = (sel_wr_a || sel_wr_b) && !reset;
        assign wr_loc = sel_wr_b ? wr_loc_b : wr_loc_a;
        assign wr_dat = sel_wr_b ? s_write_data_b : s_write_data_a;
        assign bypass = rd_en && wr_en && (rd_loc == wr_loc);

        always_ff @(posedge clk) begin
            if (wr_en)
                mem[wr_loc] <= wr_dat;
        end

        always_ff @(posedge clk) begin
            if (rd_en)
                q <= ((WRITE_FIRST != 0) && bypass) ? wr_dat : mem[rd_loc];
        end

        assign bank_q[k] = q;
    end

    // Bank registers can be overwritten by the other port, so each port keeps its own copy to hold.
    logic [TAG_W-1:0]      sel_a, sel_b;
    logic [DATA_WIDTH-1:0] hold_a, hold_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_read_valid_a <= 1'b0;
            s_read_valid_b <= 1'b0;
            sel_a          <= '0;
            sel_b          <= '0;
            hold_a         <= '0;
            hold_b         <= '0;
        end else begin
            s_read_valid_a <= rd_gnt_a;
            s_read_valid_b <= rd_gnt_b;
            if (rd_gnt_a)
                sel_a <= rd_bank_a;
            if (rd_gnt_b)
                sel_b <= rd_bank_b;
            if (s_read_valid_a)
                hold_a <= bank_q[sel_a];
            if (s_read_valid_b)
                hold_b <= bank_q[sel_b];
        end
    end

    assign s_read_data_a = s_read_valid_a ? bank_q[sel_a] : hold_a;
    assign s_read_data_b = s_read_valid_b ? bank_q[sel_b] : hold_b;

endmodule

// File: tb/tb_banked_ram_arb.sv
// Bench for banked_ram_arb: directed vector table, conflict/saturation sequence, then random traffic vs a reference model.
// A second instance built with WRITE_FIRST=0 shares every input.
module tb_banked_ram_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req_a, rd_req_b, wr_req_a, wr_req_b;
    logic [12:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [15:0] wr_data_a, wr_data_b;

    logic        rd_ready_a, rd_ready_b, rd_valid_a, rd_valid_b, wr_ready_a, wr_ready_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic [3:0]  stall_count;

    logic        rd_ready_a0, rd_ready_b0, rd_valid_a0, rd_valid_b0, wr_ready_a0, wr_ready_b0;
    logic [15:0] rd_data_a0, rd_data_b0;
    logic [15:0] stall_count0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    banked_ram_arb #(.TAG_W(2), .DATA_WIDTH(16), .ADDR_WIDTH(13), .WRITE_FIRST(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .s_read_req_a(rd_req_a), .s_read_addr_a(rd_addr_a), .s_read_ready_a(rd_ready_a),
        .s_read_data_a(rd_data_a), .s_read_valid_a(rd_valid_a),
        .s_write_req_a(wr_req_a), .s_write_addr_a(wr_addr_a), .s_write_data_a(wr_data_a),
        .s_write_ready_a(wr_ready_a),
        .s_read_req_b(rd_req_b), .s_read_addr_b(rd_addr_b), .s_read_ready_b(rd_ready_b),
        .s_read_data_b(rd_data_b), .s_read_valid_b(rd_valid_b),
        .s_write_req_b(wr_req_b), .s_write_addr_b(wr_addr_b), .s_write_data_b(wr_data_b),
        .s_write_ready_b(wr_ready_b),
        .stall_count(stall_count)
    );

    banked_ram_arb #(.TAG_W(2), .DATA_WIDTH(16), .ADDR_WIDTH(13), .WRITE_FIRST(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset),
        .s_read_req_a(rd_req_a), .s_read_addr_a(rd_addr_a), .s_read_ready_a(rd_ready_a0),
        .s_read_data_a(rd_data_a0), .s_read_valid_a(rd_valid_a0),
        .s_write_req_a(wr_req_a), .s_write_addr_a(wr_addr_a), .s_write_data_a(wr_data_a),
        .s_write_ready_a(wr_ready_a0),
        .s_read_req_b(rd_req_b), .s_read_addr_b(rd_addr_b), .s_read_ready_b(rd_ready_b0),
        .s_read_data_b(rd_data_b0), .s_read_valid_b(rd_valid_b0),
        .s_write_req_b(wr_req_b), .s_write_addr_b(wr_addr_b), .s_write_data_b(wr_data_b),
        .s_write_ready_b(wr_ready_b0),
        .stall_count(stall_count0)
    );

    typedef struct {
        logic        rst;
        logic        ra;
        logic [12:0] raa;
        logic        rb;
        logic [12:0] rab;
        logic        wa;
        logic [12:0] waa;
        logic [15:0] wda;
        logic        wb;
        logic [12:0] wab;
        logic [15:0] wdb;
        logic [3:0]  exp_rdy;
        logic        exp_va;
        logic        exp_vb;
        logic [15:0] exp_da;
        logic [15:0] exp_db;
        logic [15:0] exp_db0;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        rd_req_a  = v.ra;  rd_addr_a = v.raa;
        rd_req_b  = v.rb;  rd_addr_b = v.rab;
        wr_req_a  = v.wa;  wr_addr_a = v.waa; wr_data_a = v.wda;
        wr_req_b  = v.wb;  wr_addr_b = v.wab; wr_data_b = v.wdb;
    endtask

    task automatic clearInputs();
        reset = 1'b0;
        rd_req_a = 1'b0; rd_req_b = 1'b0; wr_req_a = 1'b0; wr_req_b = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr_a = '0; wr_addr_b = '0;
        wr_data_a = '0; wr_data_b = '0;
    endtask

    // Reference model: whole-address memory image, a "whose turn" flag per bank, expected port outputs.
    logic [15:0] m_mem [0:8191];
    bit          turn_b_rd [4];
    bit          turn_b_wr [4];
    int          m_cnt, m_cnt0;
    logic        e_va, e_vb;
    logic [15:0] e_da, e_db, e_da0, e_db0;
    bit          lg_ra, lg_rb, lg_wa, lg_wb;

    function automatic logic [15:0] readVal(input logic [12:0] a, input bit wf, input bit gwa, input bit gwb);
        if (gwa && wr_addr_a == a) return wf ? wr_data_a : m_mem[a];
        if (gwb && wr_addr_b == a) return wf ? wr_data_b : m_mem[a];
        return m_mem[a];
    endfunction

    task automatic runModelCycle();
        int  bra, brb, bwa, bwb;
        bit  rconf, wconf, g_ra, g_rb, g_wa, g_wb, stalled;
        #1;
        bra = int'(rd_addr_a) / 2048; brb = int'(rd_addr_b) / 2048;
        bwa = int'(wr_addr_a) / 2048; bwb = int'(wr_addr_b) / 2048;
        rconf = rd_req_a && rd_req_b && bra == brb;
        wconf = wr_req_a && wr_req_b && bwa == bwb;
        g_ra = rd_req_a && !(rconf && turn_b_rd[bra]);
        g_rb = rd_req_b && !(rconf && !turn_b_rd[brb]);
        g_wa = wr_req_a && !(wconf && turn_b_wr[bwa]);
        g_wb = wr_req_b && !(wconf && !turn_b_wr[bwb]);
        checkOutput("rnd_ready", {rd_ready_a, rd_ready_b, wr_ready_a, wr_ready_b}, {g_ra, g_rb, g_wa, g_wb});
        checkOutput("rnd_ready_wf0", {rd_ready_a0, rd_ready_b0, wr_ready_a0, wr_ready_b0}, {g_ra, g_rb, g_wa, g_wb});
        e_va = g_ra;
        e_vb = g_rb;
        if (g_ra) begin
            e_da  = readVal(rd_addr_a, 1'b1, g_wa, g_wb);
            e_da0 = readVal(rd_addr_a, 1'b0, g_wa, g_wb);
        end
        if (g_rb) begin
            e_db  = readVal(rd_addr_b, 1'b1, g_wa, g_wb);
            e_db0 = readVal(rd_addr_b, 1'b0, g_wa, g_wb);
        end
        if (g_wa) m_mem[wr_addr_a] = wr_data_a;
        if (g_wb) m_mem[wr_addr_b] = wr_data_b;
        if (rconf) turn_b_rd[bra] = !turn_b_rd[bra];
        if (wconf) turn_b_wr[bwa] = !turn_b_wr[bwa];
        stalled = (rd_req_a && !g_ra) || (rd_req_b && !g_rb) || (wr_req_a && !g_wa) || (wr_req_b && !g_wb);
        if (stalled) begin
            m_cnt  = (m_cnt == 15) ? 15 : m_cnt + 1;
            m_cnt0 = m_cnt0 + 1;
        end
        lg_ra = g_ra; lg_rb = g_rb; lg_wa = g_wa; lg_wb = g_wb;
        @(posedge clk);
        #1;
        checkOutput("rnd_valid", {rd_valid_a, rd_valid_b}, {e_va, e_vb});
        checkOutput("rnd_valid_wf0", {rd_valid_a0, rd_valid_b0}, {e_va, e_vb});
        checkOutput("rnd_data_a", rd_data_a, e_da);
        checkOutput("rnd_data_b", rd_data_b, e_db);
        checkOutput("rnd_data_a_wf0", rd_data_a0, e_da0);
        checkOutput("rnd_data_b_wf0", rd_data_b0, e_db0);
        checkOutput("rnd_stall", stall_count, m_cnt);
        checkOutput("rnd_stall_wf0", stall_count0, m_cnt0);
    endtask

    function automatic logic [12:0] randAddr();
        logic [1:0] bank = 2'($urandom_range(0, 3));
        logic [1:0] loc  = 2'($urandom_range(0, 3));
        return {bank, 9'b0, loc};
    endfunction

    initial begin
        clearInputs();
        reset = 1'b1;

        vecs[0]  = '{1'b1, 1'b0, 13'h0,    1'b0, 13'h0,    1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b0000, 1'b0, 1'b0, 16'h0,    16'h0,    16'h0,    4'd0};
        vecs[1]  = '{1'b0, 1'b0, 13'h0,    1'b0, 13'h0,    1'b1, 13'h0005, 16'hA005, 1'b1, 13'h0805, 16'hB805, 4'b0011, 1'b0, 1'b0, 16'h0,    16'h0,    16'h0,    4'd0};
        vecs[2]  = '{1'b0, 1'b0, 13'h0,    1'b0, 13'h0,    1'b1, 13'h1000, 16'hC000, 1'b1, 13'h0010, 16'h1234, 4'b0011, 1'b0, 1'b0, 16'h0,    16'h0,    16'h0,    4'd0};
        vecs[3]  = '{1'b0, 1'b0, 13'h0,    1'b0, 13'h0,    1'b1, 13'h1001, 16'hC001, 1'b0, 13'h0,    16'h0,    4'b0010, 1'b0, 1'b0, 16'h0,    16'h0,    16'h0,    4'd0};
        vecs[4]  = '{1'b0, 1'b1, 13'h0005, 1'b1, 13'h0805, 1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b1100, 1'b1, 1'b1, 16'hA005, 16'hB805, 16'hB805, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 13'h1000, 1'b1, 13'h1001, 1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b1000, 1'b1, 1'b0, 16'hC000, 16'hB805, 16'hB805, 4'd1};
        vecs[6]  = '{1'b0, 1'b0, 13'h0,    1'b1, 13'h1001, 1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b0100, 1'b0, 1'b1, 16'hC000, 16'hC001, 16'hC001, 4'd1};
        vecs[7]  = '{1'b0, 1'b1, 13'h1000, 1'b1, 13'h1001, 1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b0100, 1'b0, 1'b1, 16'hC000, 16'hC001, 16'hC001, 4'd2};
        vecs[8]  = '{1'b0, 1'b1, 13'h1000, 1'b0, 13'h0,    1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b1000, 1'b1, 1'b0, 16'hC000, 16'hC001, 16'hC001, 4'd2};
        vecs[9]  = '{1'b0, 1'b0, 13'h0,    1'b1, 13'h0010, 1'b1, 13'h0010, 16'hBEEF, 1'b0, 13'h0,    16'h0,    4'b0110, 1'b0, 1'b1, 16'hC000, 16'hBEEF, 16'h1234, 4'd2};
        vecs[10] = '{1'b0, 1'b0, 13'h0,    1'b1, 13'h0010, 1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b0100, 1'b0, 1'b1, 16'hC000, 16'hBEEF, 16'hBEEF, 4'd2};
        vecs[11] = '{1'b0, 1'b0, 13'h0,    1'b0, 13'h0,    1'b1, 13'h0020, 16'h1111, 1'b1, 13'h0020, 16'h2222, 4'b0010, 1'b0, 1'b0, 16'hC000, 16'hBEEF, 16'hBEEF, 4'd3};
        vecs[12] = '{1'b0, 1'b0, 13'h0,    1'b0, 13'h0,    1'b0, 13'h0,    16'h0,    1'b1, 13'h0020, 16'h2222, 4'b0001, 1'b0, 1'b0, 16'hC000, 16'hBEEF, 16'hBEEF, 4'd3};
        vecs[13] = '{1'b0, 1'b1, 13'h0020, 1'b0, 13'h0,    1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b1000, 1'b1, 1'b0, 16'h2222, 16'hBEEF, 16'hBEEF, 4'd3};
        vecs[14] = '{1'b1, 1'b1, 13'h0005, 1'b1, 13'h0805, 1'b1, 13'h0005, 16'hDEAD, 1'b0, 13'h0,    16'h0,    4'b1110, 1'b0, 1'b0, 16'h0,    16'h0,    16'h0,    4'd0};
        vecs[15] = '{1'b0, 1'b0, 13'h0,    1'b0, 13'h0,    1'b1, 13'h0030, 16'h3333, 1'b1, 13'h0031, 16'h4444, 4'b0010, 1'b0, 1'b0, 16'h0,    16'h0,    16'h0,    4'd1};
        vecs[16] = '{1'b0, 1'b0, 13'h0,    1'b0, 13'h0,    1'b0, 13'h0,    16'h0,    1'b1, 13'h0031, 16'h4444, 4'b0001, 1'b0, 1'b0, 16'h0,    16'h0,    16'h0,    4'd1};
        vecs[17] = '{1'b0, 1'b1, 13'h0005, 1'b1, 13'h1000, 1'b0, 13'h0,    16'h0,    1'b0, 13'h0,    16'h0,    4'b1100, 1'b1, 1'b1, 16'hA005, 16'hC000, 16'hC000, 4'd1};

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d_ready", i), {rd_ready_a, rd_ready_b, wr_ready_a, wr_ready_b}, vecs[i].exp_rdy);
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d_valid", i), {rd_valid_a, rd_valid_b}, {vecs[i].exp_va, vecs[i].exp_vb});
            checkOutput($sformatf("row%0d_data_a", i), rd_data_a, vecs[i].exp_da);
            checkOutput($sformatf("row%0d_data_b", i), rd_data_b, vecs[i].exp_db);
            checkOutput($sformatf("row%0d_data_b_wf0", i), rd_data_b0, vecs[i].exp_db0);
            checkOutput($sformatf("row%0d_stall", i), stall_count, vecs[i].exp_cnt);
        end

        // Permanent conflict on bank 1: grants alternate and the 4-bit counter pins at 0xF.
        for (int i = 0; i < 20; i++) begin
            int exp_cnt;
            @(negedge clk);
            clearInputs();
            rd_req_a = 1'b1; rd_addr_a = 13'h0805;
            rd_req_b = 1'b1; rd_addr_b = 13'h0805;
            #1;
            checkOutput($sformatf("sat%0d_ready", i), {rd_ready_a, rd_ready_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
            exp_cnt = (i + 2 > 15) ? 15 : i + 2;
            checkOutput($sformatf("sat%0d_stall", i), stall_count, exp_cnt);
            checkOutput($sformatf("sat%0d_data", i), (i % 2 == 0) ? rd_data_a : rd_data_b, 16'hB805);
        end

        @(negedge clk);
        clearInputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            turn_b_rd[k] = 1'b0;
            turn_b_wr[k] = 1'b0;
        end
        m_cnt = 0; m_cnt0 = 0;
        e_va = 1'b0; e_vb = 1'b0;
        e_da = '0; e_db = '0; e_da0 = '0; e_db0 = '0;

        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < 4; l++) begin
                @(negedge clk);
                clearInputs();
                wr_req_a  = 1'b1;
                wr_addr_a = {2'(b), 9'b0, 2'(l)};
                wr_data_a = 16'($urandom);
                runModelCycle();
            end
        end

        lg_ra = 1'b1; lg_rb = 1'b1; lg_wa = 1'b1; lg_wb = 1'b1;
        rd_req_a = 1'b0; rd_req_b = 1'b0; wr_req_a = 1'b0; wr_req_b = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            reset = 1'b0;
            if (!rd_req_a || lg_ra) begin
                rd_req_a = 1'($urandom_range(0, 1)); rd_addr_a = randAddr();
            end
            if (!rd_req_b || lg_rb) begin
                rd_req_b = 1'($urandom_range(0, 1)); rd_addr_b = randAddr();
            end
            if (!wr_req_a || lg_wa) begin
                wr_req_a = 1'($urandom_range(0, 1)); wr_addr_a = randAddr(); wr_data_a = 16'($urandom);
            end
            if (!wr_req_b || lg_wb) begin
                wr_req_b = 1'($urandom_range(0, 1)); wr_addr_b = randAddr(); wr_data_b = 16'($urandom);
            end
            runModelCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
